// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mult_pkg;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width for an N-bit operand.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/full_add_n_bit.sv
// N-bit ripple adder with carry in/out, used as the multiplier accumulator adder.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b (N-bit addends), i_c_in (carry in) -> o_sum (N-bit), o_c_out (carry out).
module full_add_n_bit #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c_in,
    output logic [N-1:0] o_sum,
    output logic         o_c_out
);

    logic [N:0] w_total;

    assign w_total          = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c_in};
    assign {o_c_out, o_sum} = w_total;

endmodule

// File: rtl/mult_seq_n.sv
// Sequential shift-add multiplier, signed or unsigned, N-bit operands, 2N-bit product.
// Latency: N+1 cycles from start sample to done pulse; one result per N+1 cycles back-to-back.
// Backpressure: none; start is ignored while busy, p holds until the next done.
// Ports: clk, reset (async, active-high), start/signed_mode/a/b (sampled when idle or done),
//        busy (RUN state), done (one-cycle pulse), p (registered product).
module mult_seq_n
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_mcand;     // |a|
    logic [N-1:0]   r_acc;       // upper half of the product shift register
    logic [N-1:0]   r_mplier;    // |b|, shifted out as the product low half shifts in
    logic           r_neg;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_p;

    logic           w_load, w_step, w_last;
    logic [N-1:0]   w_abs_a, w_abs_b, w_add_b, w_sum;
    logic           w_cout;
    logic [2*N-1:0] w_prod, w_prod_fix;

    // Magnitudes; -2^(N-1) negates to 2^(N-1), which is still correct read as unsigned.
    assign w_abs_a = (signed_mode && a[N-1]) ? -a : a;
    assign w_abs_b = (signed_mode && b[N-1]) ? -b : b;

    assign w_add_b = r_mplier[0] ? r_mcand : '0;

    full_add_n_bit #(.N(N)) u_add (
        .i_a     (r_acc),
        .i_b     (w_add_b),
        .i_c_in  (1'b0),
        .o_sum   (w_sum),
        .o_c_out (w_cout)
    );

    // {carry, acc, multiplier} shifted right by one: the register contents after this iteration.
    assign w_prod     = {w_cout, w_sum, r_mplier[N-1:1]};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_mcand  <= w_abs_a;
                r_mplier <= w_abs_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_neg    <= signed_mode & (a[N-1] ^ b[N-1]);
            end else if (w_step) begin
                {r_acc, r_mplier} <= w_prod;
                r_cnt             <= r_cnt + CW'(1);
            end
            // p is captured on the final iteration so it is valid in the same cycle as done.
            if (w_last) begin
                r_p <= w_prod_fix;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign p    = r_p;

endmodule

// File: tb/tb_mult_seq_n.sv
module tb_mult_seq_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        s8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        s4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    logic        s16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int errors = 0;
    int checks = 0;
    int n_done8 = 0;
    int n_done4 = 0;
    int n_done16 = 0;

    logic [15:0] q8[$];
    logic [7:0]  q4[$];
    logic [31:0] q16[$];

    mult_seq_n #(.N(8)) u_dut8 (
        .clk(clk), .reset(rst), .start(s8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8));

    mult_seq_n #(.N(4)) u_dut4 (
        .clk(clk), .reset(rst), .start(s4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4));

    mult_seq_n #(.N(16)) u_dut16 (
        .clk(clk), .reset(rst), .start(s16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .p(p16));

    // Reference product: plain integer multiply, truncated to 2n bits.
    function automatic logic [31:0] ref_mul(input int n, input logic sm,
                                            input logic [15:0] a, input logic [15:0] b);
        longint x, y, r;
        x = longint'(a);
        y = longint'(b);
        if (sm && a[n-1]) x = x - (longint'(1) << n);
        if (sm && b[n-1]) y = y - (longint'(1) << n);
        r = x * y;
        r = r & ((longint'(1) << (2 * n)) - 1);
        return r[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: every done pulse pops the oldest expected product.
    always @(posedge clk) begin
        #1;
        if (done8) begin
            n_done8++;
            if (q8.size() == 0) chk("p8_unexpected_done", 32'(q8.size()), 32'd1);
            else                chk("p8", 32'(p8), 32'(q8.pop_front()));
        end
    end

    always @(posedge clk) begin
        #1;
        if (done4) begin
            n_done4++;
            if (q4.size() == 0) chk("p4_unexpected_done", 32'(q4.size()), 32'd1);
            else                chk("p4", 32'(p4), 32'(q4.pop_front()));
        end
    end

    always @(posedge clk) begin
        #1;
        if (done16) begin
            n_done16++;
            if (q16.size() == 0) chk("p16_unexpected_done", 32'(q16.size()), 32'd1);
            else                 chk("p16", p16, q16.pop_front());
        end
    end

    // One N=8 operation: start for one edge, operands scrambled afterwards,
    // optional extra start pulse during RUN. Returns edges to done and busy cycles seen.
    task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int pulse_at,
                        output int lat, output int bcnt);
        @(negedge clk);
        s8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        q8.push_back(exp);
        lat  = 0;
        bcnt = 0;
        while (lat < 50) begin
            @(posedge clk); #1;
            lat++;
            s8  = 1'b0;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            sm8 = 1'($urandom);
            if (lat == pulse_at) begin
                s8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
            end
            if (busy8) bcnt++;
            if (done8) break;
        end
        s8 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, bcnt, nd, nd4, nd16, cyc, last, ndone;
        logic [15:0] bexp [3];
        logic [3:0]  x4, y4;
        logic [15:0] x16, y16;
        logic        m4, m16;

        rst = 1'b1;
        s8 = 1'b0;  sm8 = 1'b0;  a8 = '0;  b8 = '0;
        s4 = 1'b0;  sm4 = 1'b0;  a4 = '0;  b4 = '0;
        s16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_p", 32'(p8), 32'd0);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned max x max: latency and busy width.
        run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 0, lat, bcnt);
        chk("lat_255x255", 32'(lat), 32'd9);
        chk("busy_cycles", 32'(bcnt), 32'd8);
        repeat (3) @(posedge clk);
        #1;
        chk("p_hold_idle", 32'(p8), 32'h0000FE01);

        // Signed corners, zero and identity.
        run8(1'b1, 8'h80, 8'h80, 16'h4000, 0, lat, bcnt);
        chk("lat_m128sq", 32'(lat), 32'd9);
        run8(1'b1, 8'hFD, 8'h05, 16'hFFF1, 0, lat, bcnt);
        run8(1'b1, 8'h7F, 8'h80, 16'hC080, 0, lat, bcnt);
        run8(1'b0, 8'h00, 8'hA5, 16'h0000, 0, lat, bcnt);
        run8(1'b1, 8'h01, 8'hFF, 16'hFFFF, 0, lat, bcnt);

        // start pulsed mid-RUN is ignored.
        nd = n_done8;
        run8(1'b0, 8'd10, 8'd20, 16'd200, 3, lat, bcnt);
        chk("lat_with_pulse", 32'(lat), 32'd9);
        repeat (15) @(posedge clk);
        #1;
        chk("one_done_pulse", 32'(n_done8 - nd), 32'd1);

        // start held high: back-to-back, new operands accepted in DONE.
        bexp[0] = 16'd63;
        bexp[1] = 16'd600;
        bexp[2] = 16'hFF1F;
        @(negedge clk);
        s8 = 1'b1; sm8 = 1'b0; a8 = 8'd7; b8 = 8'd9;
        q8.push_back(bexp[0]);
        cyc = 0; last = 0; ndone = 0;
        while (cyc < 60 && ndone < 3) begin
            @(posedge clk); #1;
            cyc++;
            if (done8) begin
                ndone++;
                chk("b2b_gap", 32'(cyc - last), 32'd9);
                last = cyc;
                if (ndone == 1) begin
                    a8 = 8'd200; b8 = 8'd3;
                    q8.push_back(bexp[1]);
                end else if (ndone == 2) begin
                    sm8 = 1'b1; a8 = 8'hF1; b8 = 8'h0F;
                    q8.push_back(bexp[2]);
                end else begin
                    s8 = 1'b0;
                end
            end else if (ndone > 0 && cyc == last + 4) begin
                chk("b2b_hold", 32'(p8), 32'(bexp[ndone-1]));
            end
        end
        s8 = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd3);

        // Reset in the 4th RUN cycle aborts with no visible result.
        @(negedge clk);
        s8 = 1'b1; sm8 = 1'b0; a8 = 8'd100; b8 = 8'd100;
        q8.push_back(16'd10000);
        bcnt = 0; lat = 0;
        while (bcnt < 4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            s8 = 1'b0;
            if (busy8) bcnt++;
        end
        rst = 1'b1;
        q8.delete();
        #1;
        chk("abort_p", 32'(p8), 32'd0);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run8(1'b0, 8'd12, 8'd12, 16'd144, 0, lat, bcnt);
        chk("lat_after_abort", 32'(lat), 32'd9);

        // N=4 and N=16 sweep against the reference model.
        for (int i = 0; i < 24; i++) begin
            if (i == 0) begin
                m4 = 1'b1; x4 = 4'h8; y4 = 4'h8;
                m16 = 1'b1; x16 = 16'h8000; y16 = 16'h8000;
            end else if (i == 1) begin
                m4 = 1'b0; x4 = 4'hF; y4 = 4'hF;
                m16 = 1'b0; x16 = 16'hFFFF; y16 = 16'hFFFF;
            end else begin
                m4 = 1'($urandom); x4 = 4'($urandom); y4 = 4'($urandom);
                m16 = 1'($urandom); x16 = 16'($urandom); y16 = 16'($urandom);
            end
            @(negedge clk);
            s4 = 1'b1;  sm4 = m4;   a4 = x4;   b4 = y4;
            s16 = 1'b1; sm16 = m16; a16 = x16; b16 = y16;
            q4.push_back(8'(ref_mul(4, m4, 16'(x4), 16'(y4))));
            q16.push_back(ref_mul(16, m16, x16, y16));
            nd4  = n_done4 + 1;
            nd16 = n_done16 + 1;
            @(posedge clk); #1;
            s4 = 1'b0; s16 = 1'b0;
            a4 = 4'($urandom); a16 = 16'($urandom);
            cyc = 0;
            while ((n_done4 < nd4 || n_done16 < nd16) && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("sweep_done_in_time", 32'(cyc < 40), 32'd1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
